// File: rtl/treeval_pkg.sv
// Shared opcodes, FSM states and encodings for the treeval command sequencer.
package treeval_pkg;

  typedef enum logic [2:0] {
    OP_NODES  = 3'd0,
    OP_PAR    = 3'd1,
    OP_REW    = 3'd2,
    OP_ACT    = 3'd3,
    OP_WEIGHT = 3'd4,
    OP_RUN    = 3'd5
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_START  = 2'd1,
    ST_WAIT   = 2'd2,
    ST_RESULT = 2'd3
  } state_e;

  localparam logic [2:0] ACT_PLAY    = 3'b001;
  localparam logic [2:0] ACT_NO_PLAY = 3'b000;
  localparam logic       STRAT_MAX   = 1'b1;
  localparam logic       STRAT_MIN   = 1'b0;

  localparam int DEF_W_ADDR       = 10;
  localparam int DEF_W_N_DATA     = 10;
  localparam int DEF_W_C_DATA     = 10;
  localparam int DEF_W_REWARD     = 10;
  localparam int DEF_W_ACTION     = 3;
  localparam int DEF_EVAL_TIMEOUT = 64;

endpackage

// File: rtl/treeval_seq.sv
// Host command sequencer for treeval: registers config/memory write strobes,
// runs an evaluation with a bounded wait and returns the result over valid/ready.
module treeval_seq
  import treeval_pkg::*;
#(
  parameter int W_ADDR       = DEF_W_ADDR,
  parameter int W_N_DATA     = DEF_W_N_DATA,
  parameter int W_C_DATA     = DEF_W_C_DATA,
  parameter int W_REWARD     = DEF_W_REWARD,
  parameter int W_ACTION     = DEF_W_ACTION,
  parameter int EVAL_TIMEOUT = DEF_EVAL_TIMEOUT
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [2:0]          cmd_op,
  input  logic [W_ADDR-1:0]   cmd_addr,
  input  logic [W_N_DATA-1:0] cmd_data,
  output logic                tv_rst,
  output logic                tv_conf_nodes,
  output logic                tv_mem_par,
  output logic                tv_mem_rew,
  output logic                tv_mem_act,
  output logic                tv_mem_weight,
  output logic [W_ADDR-1:0]   tv_mem_addr,
  output logic [W_N_DATA-1:0] tv_mem_data,
  output logic [W_C_DATA-1:0] tv_conf_data,
  input  logic                tv_exp_change,
  input  logic [W_REWARD-1:0] tv_exp,
  input  logic [W_ACTION-1:0] tv_act,
  output logic                res_valid,
  input  logic                res_ready,
  output logic [W_REWARD-1:0] res_exp,
  output logic [W_ACTION-1:0] res_act,
  output logic                res_timeout,
  output logic                busy,
  output logic [1:0]          err
);

  localparam int CNT_W = (EVAL_TIMEOUT > 2) ? $clog2(EVAL_TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(EVAL_TIMEOUT - 1);
  localparam int CMP_W = (W_ADDR > W_C_DATA) ? W_ADDR : W_C_DATA;

  state_e                state, state_n;
  logic [CNT_W-1:0]      cnt;
  logic [W_C_DATA-1:0]   node_cnt;
  logic signed [W_REWARD-1:0] res_exp_q;
  logic [CMP_W-1:0]      addr_x, cnt_x;
  logic                  cmd_acc, addr_ok, par_ok, cnt_zero;

  assign addr_x   = CMP_W'(cmd_addr);
  assign cnt_x    = CMP_W'(node_cnt);
  assign addr_ok  = (addr_x < cnt_x);
  assign par_ok   = addr_ok && (cmd_addr != '0);
  assign cnt_zero = (node_cnt == '0);

  // cmd_ready is also held low while reset is asserted so every output reads 0 then
  assign cmd_ready = rst && (state == ST_IDLE);
  assign cmd_acc   = cmd_valid && (state == ST_IDLE);
  assign busy      = (state != ST_IDLE);
  assign res_valid = (state == ST_RESULT);
  assign res_exp   = res_exp_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ST_IDLE;
    else      state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      ST_IDLE:   if (cmd_valid && cmd_op == OP_RUN)
                   state_n = cnt_zero ? ST_RESULT : ST_START;
      ST_START:  state_n = ST_WAIT;
      ST_WAIT:   if (tv_exp_change || cnt == CNT_LAST) state_n = ST_RESULT;
      ST_RESULT: if (res_ready) state_n = ST_IDLE;
      default:   state_n = ST_IDLE;
    endcase
  end

  // ---- command decode / write strobe stage ----
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tv_rst        <= 1'b0;
      tv_conf_nodes <= 1'b0;
      tv_mem_par    <= 1'b0;
      tv_mem_rew    <= 1'b0;
      tv_mem_act    <= 1'b0;
      tv_mem_weight <= 1'b0;
      tv_mem_addr   <= '0;
      tv_mem_data   <= '0;
      tv_conf_data  <= '0;
      node_cnt      <= '0;
      err           <= 2'b00;
    end else begin
      tv_rst        <= 1'b0;
      tv_conf_nodes <= 1'b0;
      tv_mem_par    <= 1'b0;
      tv_mem_rew    <= 1'b0;
      tv_mem_act    <= 1'b0;
      tv_mem_weight <= 1'b0;
      if (cmd_acc) begin
        case (cmd_op)
          OP_NODES: begin
            node_cnt      <= cmd_data[W_C_DATA-1:0];
            tv_conf_data  <= cmd_data[W_C_DATA-1:0];
            tv_conf_nodes <= 1'b1;
          end
          OP_PAR: begin
            if (par_ok) begin
              tv_mem_par  <= 1'b1;
              tv_mem_addr <= cmd_addr;
              tv_mem_data <= cmd_data;
            end else err[0] <= 1'b1;
          end
          OP_REW, OP_ACT, OP_WEIGHT: begin
            if (addr_ok) begin
              tv_mem_rew    <= (cmd_op == OP_REW);
              tv_mem_act    <= (cmd_op == OP_ACT);
              tv_mem_weight <= (cmd_op == OP_WEIGHT);
              tv_mem_addr   <= cmd_addr;
              tv_mem_data   <= cmd_data;
            end else err[0] <= 1'b1;
          end
          OP_RUN:  tv_rst <= !cnt_zero;
          default: err[1] <= 1'b1;
        endcase
      end
    end
  end

  // ---- evaluation wait / result capture stage ----
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt         <= '0;
      res_exp_q   <= '0;
      res_act     <= '0;
      res_timeout <= 1'b0;
    end else begin
      if (cmd_acc && cmd_op == OP_RUN && cnt_zero) begin
        res_exp_q   <= '0;
        res_act     <= '0;
        res_timeout <= 1'b1;
      end
      if (state == ST_START) cnt <= '0;
      if (state == ST_WAIT) begin
        cnt <= cnt + 1'b1;
        if (tv_exp_change) begin
          res_exp_q   <= tv_exp;
          res_act     <= tv_act;
          res_timeout <= 1'b0;
        end else if (cnt == CNT_LAST) begin
          res_exp_q   <= '0;
          res_act     <= '0;
          res_timeout <= 1'b1;
        end
      end
    end
  end

endmodule
